hangman_engine: RTL

//  Parametrised successor game core for the word-guess design. Word length, character width
//  and try budget are all parameters. All letter positions are checked in parallel in one cycle.

---
 rtl/hangman_pkg.sv | 17 +
 rtl/hangman_match.sv | 21 ++
 rtl/hangman_engine.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman game core.
package hangman_pkg;

  // Game controller states; IDLE must encode as zero so reset lands there.
  typedef enum logic [3:0] {
    HM_IDLE  = 4'd0,
    HM_LOAD  = 4'd1,
    HM_WAIT  = 4'd2,
    HM_CHECK = 4'd3,
    HM_WIN   = 4'd4,
    HM_LOSE  = 4'd5
  } hm_state_t;

  // Letter code reserved for blank/padding positions.
  localparam int HM_BLANK = 0;

endpackage

// File: rtl/hangman_match.sv
// Parallel letter comparator: flags every word position equal to the guess.
// A blank guess never matches, so padding positions cannot be "hit".
module hangman_match
  import hangman_pkg::*;
#(
  parameter int WORD_LEN = 5,
  parameter int CHAR_W   = 5
) (
  input  logic [WORD_LEN-1:0][CHAR_W-1:0] word_i,
  input  logic [CHAR_W-1:0]               guess_i,
  output logic [WORD_LEN-1:0]             match_o
);

  logic guess_nz;
  assign guess_nz = (guess_i != CHAR_W'(HM_BLANK));

  for (genvar i = 0; i < WORD_LEN; i++) begin : g_lane
    assign match_o[i] = guess_nz && (word_i[i] == guess_i);
  end

endmodule

// File: rtl/hangman_engine.sv
// Hangman game core: loads a word, accepts guesses over valid/ready,
// reveals all matching positions in one cycle, tracks wrong tries and
// ignores repeated guesses without charging a try.
module hangman_engine
  import hangman_pkg::*;
#(
  parameter  int WORD_LEN  = 5,
  parameter  int CHAR_W    = 5,
  parameter  int MAX_TRIES = 7,
  localparam int TRY_W     = $clog2(MAX_TRIES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [WORD_LEN*CHAR_W-1:0] word_i,
  input  logic                       guess_valid_i,
  input  logic [CHAR_W-1:0]          guess_i,
  output logic                       guess_ready_o,
  output logic [WORD_LEN-1:0]        revealed_o,
  output logic [TRY_W-1:0]           tries_o,
  output logic                       hit_o,
  output logic                       miss_o,
  output logic                       repeat_o,
  output logic                       win_o,
  output logic                       lose_o
);

  localparam int HIST_N = 2 ** CHAR_W;

  if (WORD_LEN < 1 || WORD_LEN > 16) begin : g_bad_len
    $fatal(1, "hangman_engine: WORD_LEN must be 1..16");
  end
  if (MAX_TRIES < 1 || MAX_TRIES >= 2 ** TRY_W) begin : g_bad_tries
    $fatal(1, "hangman_engine: MAX_TRIES out of range for TRY_W");
  end

  hm_state_t                       state_q, state_d;
  logic [WORD_LEN-1:0][CHAR_W-1:0] word_q, word_d, word_in;
  logic [CHAR_W-1:0]               guess_q, guess_d;
  logic [HIST_N-1:0]               hist_q, hist_d;
  logic [WORD_LEN-1:0]             rev_q, rev_d, pad, match;
  logic [TRY_W-1:0]                tries_q, tries_d;
  logic                            hit_q, hit_d, miss_q, miss_d, rep_q, rep_d;

  assign word_in = word_i;

  hangman_match #(.WORD_LEN(WORD_LEN), .CHAR_W(CHAR_W)) u_match (
    .word_i  (word_q),
    .guess_i (guess_q),
    .match_o (match)
  );

  // Padding letters of the incoming word start out revealed.
  always_comb begin
    pad = '0;
    for (int i = 0; i < WORD_LEN; i++) pad[i] = (word_in[i] == CHAR_W'(HM_BLANK));
  end

  // Next-state and datapath update; start_i overrides everything but reset.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    guess_d = guess_q;
    hist_d  = hist_q;
    rev_d   = rev_q;
    tries_d = tries_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    rep_d   = 1'b0;
    if (start_i) begin
      word_d  = word_in;
      guess_d = '0;
      hist_d  = '0;
      rev_d   = pad;
      tries_d = '0;
      state_d = HM_LOAD;
    end else begin
      unique case (state_q)
        HM_IDLE: ;
        // An all-blank word is already solved.
        HM_LOAD: state_d = (&rev_q) ? HM_WIN : HM_WAIT;
        HM_WAIT: begin
          if (guess_valid_i) begin
            guess_d = guess_i;
            state_d = HM_CHECK;
          end
        end
        HM_CHECK: begin
          if (guess_q == CHAR_W'(HM_BLANK) || hist_q[guess_q]) begin
            rep_d = 1'b1;
          end else begin
            hist_d[guess_q] = 1'b1;
            if (|match) begin
              rev_d = rev_q | match;
              hit_d = 1'b1;
            end else begin
              if (tries_q != TRY_W'(MAX_TRIES)) tries_d = tries_q + TRY_W'(1);
              miss_d = 1'b1;
            end
          end
          // Completing the word wins even on what would be the last try.
          if (&rev_d)                            state_d = HM_WIN;
          else if (tries_d == TRY_W'(MAX_TRIES)) state_d = HM_LOSE;
          else                                   state_d = HM_WAIT;
        end
        HM_WIN, HM_LOSE: ;
        default: state_d = HM_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HM_IDLE;
      word_q  <= '0;
      guess_q <= '0;
      hist_q  <= '0;
      rev_q   <= '0;
      tries_q <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      guess_q <= guess_d;
      hist_q  <= hist_d;
      rev_q   <= rev_d;
      tries_q <= tries_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      rep_q   <= rep_d;
    end
  end

  assign guess_ready_o = (state_q == HM_WAIT);
  assign revealed_o    = rev_q;
  assign tries_o       = tries_q;
  assign hit_o         = hit_q;
  assign miss_o        = miss_q;
  assign repeat_o      = rep_q;
  assign win_o         = (state_q == HM_WIN);
  assign lose_o        = (state_q == HM_LOSE);

endmodule
